// File: rtl/lsu_dmem_port.sv
// Load/store unit data-memory port: one request at a time, RV32I widths,
// word-crossing accesses optionally split into two memory beats.
module lsu_dmem_port #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_din,
  output logic [3:0]  mem_we,
  input  logic [31:0] mem_dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_BEAT1 = 2'd1;
  localparam logic [1:0] S_BEAT2 = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]  r_state;
  logic        r_we;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_cross;
  logic        r_err;
  logic [31:0] r_w1;
  logic [23:0] r_w2;

  logic        w_illegal;
  logic        w_cross;
  logic        w_err;
  logic [1:0]  w_k;
  logic [31:0] w_base;
  logic [31:0] w_din_rot;
  logic [3:0]  w_mask_base;
  logic [7:0]  w_mask8;
  logic [31:0] w_raw;
  logic [31:0] w_ext;

  // Request decode, evaluated on the live request fields at handshake time.
  always_comb begin
    w_illegal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: w_illegal = 1'b0;
      3'b100, 3'b101:         w_illegal = req_we;
      default:                w_illegal = 1'b1;
    endcase
    w_cross = ((req_funct3[1:0] == 2'b01) && (req_addr[1:0] == 2'b11)) ||
              ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_err   = w_illegal || (w_cross && !MISALIGN_EN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cross <= 1'b0;
      r_err   <= 1'b0;
      r_w1    <= '0;
      r_w2    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cross <= w_cross;
            r_err   <= w_err;
            r_w2    <= '0;
            r_state <= w_err ? S_RESP : S_BEAT1;
          end
        end
        S_BEAT1: begin
          r_w1    <= mem_dout;
          r_state <= r_cross ? S_BEAT2 : S_RESP;
        end
        S_BEAT2: begin
          r_w2    <= mem_dout[23:0];
          r_state <= S_RESP;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_k    = r_addr[1:0];
  assign w_base = {r_addr[31:2], 2'b00};

  always_comb begin
    w_din_rot = r_wdata;
    case (w_k)
      2'd1:    w_din_rot = {r_wdata[23:0], r_wdata[31:24]};
      2'd2:    w_din_rot = {r_wdata[15:0], r_wdata[31:16]};
      2'd3:    w_din_rot = {r_wdata[7:0],  r_wdata[31:8]};
      default: w_din_rot = r_wdata;
    endcase
  end

  always_comb begin
    w_mask_base = 4'b1111;
    case (r_f3[1:0])
      2'b00:   w_mask_base = 4'b0001;
      2'b01:   w_mask_base = 4'b0011;
      default: w_mask_base = 4'b1111;
    endcase
    w_mask8 = {4'b0000, w_mask_base} << w_k;
  end

  // Byte-granular funnel shift of {w2,w1}; w2 top byte never reaches the result.
  always_comb begin
    w_raw = r_w1;
    case (w_k)
      2'd1:    w_raw = {r_w2[7:0],  r_w1[31:8]};
      2'd2:    w_raw = {r_w2[15:0], r_w1[31:16]};
      2'd3:    w_raw = {r_w2[23:0], r_w1[31:24]};
      default: w_raw = r_w1;
    endcase
  end

  always_comb begin
    w_ext = w_raw;
    case (r_f3)
      3'b000:  w_ext = {{24{w_raw[7]}},  w_raw[7:0]};
      3'b001:  w_ext = {{16{w_raw[15]}}, w_raw[15:0]};
      3'b100:  w_ext = {24'd0, w_raw[7:0]};
      3'b101:  w_ext = {16'd0, w_raw[15:0]};
      default: w_ext = w_raw;
    endcase
  end

  always_comb begin
    req_ready = (r_state == S_IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = '0;
    mem_addr  = '0;
    mem_din   = '0;
    mem_we    = '0;
    case (r_state)
      S_BEAT1: begin
        mem_addr = w_base;
        mem_din  = w_din_rot;
        if (r_we) mem_we = w_mask8[3:0];
      end
      S_BEAT2: begin
        mem_addr = w_base + 32'd4;
        mem_din  = w_din_rot;
        if (r_we) mem_we = w_mask8[7:4];
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = r_err;
        if (!r_we && !r_err) rsp_rdata = w_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Scoreboard bench for lsu_dmem_port: split-beat instance plus a no-split instance.
module tb_lsu_dmem_port;

  logic        clk;
  logic        rst_n;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        req_valid, req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata, mem_addr, mem_din, mem_dout;
  logic [3:0]  mem_we;

  logic        req_valid0, req_ready0, rsp_valid0, rsp_err0;
  logic [31:0] rsp_rdata0, mem_addr0, mem_din0, mem_dout0;
  logic [3:0]  mem_we0;

  int checks;
  int errors;
  int cyc;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t q0[$];

  logic [31:0] mem [1024];
  logic        mem_clr;

  lsu_dmem_port #(.MISALIGN_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  lsu_dmem_port #(.MISALIGN_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0),
    .mem_addr(mem_addr0), .mem_din(mem_din0), .mem_we(mem_we0), .mem_dout(mem_dout0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Data memory: combinational read, byte-lane writes on the falling edge.
  always @(negedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (mem_we[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_din[8*b +: 8];
    end
  end
  assign mem_dout  = mem[mem_addr[11:2]];
  assign mem_dout0 = mem[mem_addr0[11:2]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rsp_valid) begin
      if (q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = q.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
        chk("rsp_rdata", rsp_rdata, e.rdata);
        chk("rsp_cycle", cyc, e.cyc);
      end
    end else if (q.size() != 0 && cyc > q[0].cyc) begin
      chk("rsp_missing", 32'd0, 32'd1);
      void'(q.pop_front());
    end
  end

  always @(negedge clk) begin : mon0
    exp_t e;
    if (rsp_valid0) begin
      if (q0.size() == 0) chk("unexpected_rsp0", 32'd1, 32'd0);
      else begin
        e = q0.pop_front();
        chk("rsp_err0", {31'd0, rsp_err0}, {31'd0, e.err});
        chk("rsp_rdata0", rsp_rdata0, e.rdata);
        chk("rsp_cycle0", cyc, e.cyc);
      end
    end else if (q0.size() != 0 && cyc > q0[0].cyc) begin
      chk("rsp_missing0", 32'd0, 32'd1);
      void'(q0.pop_front());
    end
  end

  // Called and returns at #1 after a rising edge. nb = expected memory beats.
  task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int nb,
                       input logic [3:0] ew1, input logic [31:0] ea1,
                       input logic [3:0] ew2, input logic [31:0] ea2,
                       input logic [31:0] ed, input logic eerr, input logic [31:0] erd);
    exp_t e;
    int   n;
    n = 0;
    while (!(sel ? req_ready0 : req_ready) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!(sel ? req_ready0 : req_ready)) chk("ready_timeout", 32'd0, 32'd1);
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    if (sel) req_valid0 = 1'b1; else req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_valid0 = 1'b0;
    e.err   = eerr;
    e.rdata = erd;
    e.cyc   = cyc + ((nb == 0) ? 1 : nb + 1) - 1;
    if (sel) q0.push_back(e); else q.push_back(e);
    if (nb == 0) begin
      chk("err_no_we", {28'd0, sel ? mem_we0 : mem_we}, 32'd0);
    end else begin
      chk("beat1_we", {28'd0, sel ? mem_we0 : mem_we}, {28'd0, ew1});
      chk("beat1_addr", sel ? mem_addr0 : mem_addr, ea1);
      if (we) chk("beat1_din", sel ? mem_din0 : mem_din, ed);
      if (nb == 2) begin
        @(posedge clk); #1;
        chk("beat2_we", {28'd0, sel ? mem_we0 : mem_we}, {28'd0, ew2});
        chk("beat2_addr", sel ? mem_addr0 : mem_addr, ea2);
        if (we) chk("beat2_din", sel ? mem_din0 : mem_din, ed);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_we", {28'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_din", mem_din, 32'd0);
    chk("rst_ready0", {31'd0, req_ready0}, 32'd1);
    rst_n = 1'b1; mem_clr = 1'b0;
    @(posedge clk); #1;

    //    sel we  f3      addr          wdata        nb ew1      ea1           ew2      ea2   din          err   rdata
    issue(0, 1, 3'b010, 32'h10,       32'hDEADBEEF, 1, 4'b1111, 32'h10,       4'b0000, 32'h0, 32'hDEADBEEF, 1'b0, 32'h0);
    issue(0, 0, 3'b010, 32'h10,       32'h0,        1, 4'b0000, 32'h10,       4'b0000, 32'h0, 32'h0,        1'b0, 32'hDEADBEEF);
    issue(0, 1, 3'b000, 32'h13,       32'h000000A5, 1, 4'b1000, 32'h10,       4'b0000, 32'h0, 32'hA5000000, 1'b0, 32'h0);
    issue(0, 0, 3'b000, 32'h13,       32'h0,        1, 4'b0000, 32'h10,       4'b0000, 32'h0, 32'h0,        1'b0, 32'hFFFFFFA5);
    issue(0, 0, 3'b100, 32'h13,       32'h0,        1, 4'b0000, 32'h10,       4'b0000, 32'h0, 32'h0,        1'b0, 32'h000000A5);
    issue(0, 0, 3'b001, 32'h12,       32'h0,        1, 4'b0000, 32'h10,       4'b0000, 32'h0, 32'h0,        1'b0, 32'hFFFFA5AD);
    issue(0, 1, 3'b010, 32'h20,       32'h44332211, 1, 4'b1111, 32'h20,       4'b0000, 32'h0, 32'h44332211, 1'b0, 32'h0);
    issue(0, 1, 3'b010, 32'h24,       32'h88776655, 1, 4'b1111, 32'h24,       4'b0000, 32'h0, 32'h88776655, 1'b0, 32'h0);
    issue(0, 0, 3'b010, 32'h22,       32'h0,        2, 4'b0000, 32'h20,       4'b0000, 32'h24, 32'h0,       1'b0, 32'h66554433);
    issue(0, 1, 3'b001, 32'h1F,       32'h0000BEEF, 2, 4'b1000, 32'h1C,       4'b0001, 32'h20, 32'hEF0000BE, 1'b0, 32'h0);
    issue(0, 0, 3'b101, 32'h1F,       32'h0,        2, 4'b0000, 32'h1C,       4'b0000, 32'h20, 32'h0,       1'b0, 32'h0000BEEF);
    issue(0, 0, 3'b011, 32'h0,        32'h0,        0, 4'b0000, 32'h0,        4'b0000, 32'h0, 32'h0,        1'b1, 32'h0);
    issue(0, 1, 3'b100, 32'h10,       32'h0,        0, 4'b0000, 32'h0,        4'b0000, 32'h0, 32'h0,        1'b1, 32'h0);
    issue(0, 1, 3'b010, 32'hFFFFFFFE, 32'h12345678, 2, 4'b1100, 32'hFFFFFFFC, 4'b0011, 32'h0, 32'h56781234, 1'b0, 32'h0);
    issue(0, 0, 3'b010, 32'hFFFFFFFE, 32'h0,        2, 4'b0000, 32'hFFFFFFFC, 4'b0000, 32'h0, 32'h0,        1'b0, 32'h12345678);
    issue(1, 0, 3'b010, 32'h02,       32'h0,        0, 4'b0000, 32'h0,        4'b0000, 32'h0, 32'h0,        1'b1, 32'h0);
    issue(1, 1, 3'b001, 32'h1F,       32'h0000BEEF, 0, 4'b0000, 32'h0,        4'b0000, 32'h0, 32'h0,        1'b1, 32'h0);
    issue(1, 0, 3'b010, 32'h10,       32'h0,        1, 4'b0000, 32'h10,       4'b0000, 32'h0, 32'h0,        1'b0, 32'hA5ADBEEF);
    issue(1, 0, 3'b001, 32'h1E,       32'h0,        1, 4'b0000, 32'h1C,       4'b0000, 32'h0, 32'h0,        1'b0, 32'hFFFFEF00);

    // Abort a crossing store in its second beat.
    while (!req_ready) begin @(posedge clk); #1; end
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h2A; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_beat1_we", {28'd0, mem_we}, {28'd0, 4'b1100});
    @(posedge clk); #1;
    chk("abort_beat2_we", {28'd0, mem_we}, {28'd0, 4'b0011});
    rst_n = 1'b0;
    #1;
    chk("abort_mem_we", {28'd0, mem_we}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_mem_addr", mem_addr, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    issue(0, 0, 3'b010, 32'h10, 32'h0, 1, 4'b0000, 32'h10, 4'b0000, 32'h0, 32'h0, 1'b0, 32'hA5ADBEEF);

    repeat (6) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 32'd0);
    chk("queue0_drained", q0.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_dmem_port.md
LSU_DMEM_PORT -- requirements
Module: lsu_dmem_port

Interface
REQ-001 The block SHALL have parameter MISALIGN_EN, default 1, meaning word-crossing accesses are split into two beats (0 = flag them as errors).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid, input, 1, pipeline access request.
REQ-005 The block SHALL have port req_ready, output, 1, high only in IDLE.
REQ-006 The block SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-007 The block SHALL have port req_funct3, input, 3, RV32I width/sign code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 The block SHALL have port req_addr, input, 32, byte address.
REQ-009 The block SHALL have port req_wdata, input, 32, store data, right-justified.
REQ-010 The block SHALL have port rsp_valid, output, 1, one-cycle completion pulse.
REQ-011 The block SHALL have port rsp_rdata, output, 32, extended load data (0 for stores and errors).
REQ-012 The block SHALL have port rsp_err, output, 1, illegal funct3 or disallowed misalignment, valid with rsp_valid.
REQ-013 The block SHALL have port mem_addr, output, 32, data-memory byte address (memory indexes addr[11:2]).
REQ-014 The block SHALL have port mem_din, output, 32, data-memory write data.
REQ-015 The block SHALL have port mem_we, output, 4, per-byte-lane write enables (memory writes on falling clk).
REQ-016 The block SHALL have port mem_dout, input, 32, data-memory combinational read word.

Function
REQ-017 States SHALL be IDLE, BEAT1, BEAT2, RESP; a handshake (req_valid & req_ready at a rising edge) SHALL latch all req_* fields and move IDLE->BEAT1, or IDLE->RESP with rsp_err=1 on an error.
REQ-018 Legal codes: loads 000/001/010/100/101; stores 000/001/010; all others SHALL be errors with no memory access.
REQ-019 Let k = addr[1:0], W = {addr[31:2],2'b00}; an access SHALL be crossing when (H and k=3) or (W and k!=0).
REQ-020 A crossing access with MISALIGN_EN=0 SHALL be an error; with MISALIGN_EN=1 it SHALL go BEAT1->BEAT2->RESP, otherwise BEAT1->RESP.
REQ-021 BEAT1 SHALL drive mem_addr=W; BEAT2 SHALL drive mem_addr=W+4 modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
REQ-022 mem_din SHALL equal req_wdata rotated left by 8*k in both beats.
REQ-023 Store lane mask M = (B:4'b0001, H:4'b0011, W:4'b1111) placed at an 8-bit window shifted left by k; BEAT1 mem_we = M[3:0], BEAT2 mem_we = M[7:4].
REQ-024 mem_we SHALL be 4'b0000 in IDLE, RESP, all load beats, and whenever rst_n is low.
REQ-025 Loads SHALL capture mem_dout at the end of BEAT1 (w1) and BEAT2 (w2); raw = ({w2,w1} >> 8k)[31:0], w2 = 0 for non-crossing.
REQ-026 rsp_rdata SHALL be raw sign-extended from bit 7 (000) or bit 15 (001), zero-extended (100/101), or raw (010).
REQ-027 RESP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; rsp_valid SHALL not depend on downstream back-pressure.
REQ-028 Latency: rsp_valid SHALL be high 2 cycles after the handshake edge for a one-beat access, 3 for two-beat, 1 for errors.
REQ-029 req_valid while busy SHALL be ignored (req_ready=0); no request is queued.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, req_ready=1, rsp_valid=0, rsp_err=0, rsp_rdata=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-031 Reset asserted during BEAT1/BEAT2 SHALL abort the access with no response; a store's already-completed BEAT1 write is not undone.

Verification
REQ-032 SW addr 0x10, wdata 0xDEADBEEF -> one beat, mem_we=1111, mem_addr=0x10, rsp_valid 2 cycles later, rsp_err=0.
REQ-033 SB addr 0x13, wdata 0x000000A5 -> mem_we=1000, mem_din=0xA5xxxxxx; LB 0x13 -> rsp_rdata=0xFFFFFFA5; LBU -> 0x000000A5.
REQ-034 Word 0x20=0x44332211, 0x24=0x88776655; LW addr 0x22 -> beats at 0x20 then 0x24, rsp_rdata=0x66554433, latency 3.
REQ-035 SH addr 0x1F, wdata 0x0000BEEF, MISALIGN_EN=1 -> BEAT1 mem_we=1000 @0x1C, BEAT2 mem_we=0001 @0x20; LHU 0x1F -> 0x0000BEEF.
REQ-036 LW addr 0x02 with MISALIGN_EN=0, or funct3=011 -> no memory beat, rsp_valid next cycle, rsp_err=1, rsp_rdata=0.
REQ-037 rst_n pulsed low during BEAT2 of a crossing SW -> mem_we=0 at once, no rsp_valid, req_ready=1; next request completes normally.
